// File: rtl/reg_alu_pkg.sv
// Shared types for the regfile ALU sequencer: opcodes, FSM states and the
// 16-bit instruction layout with its field decoder.
package reg_alu_pkg;

    localparam int INSTR_W   = 16;
    localparam int IMM_W     = 7;
    localparam int REG_IDX_W = 2;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 11;
    localparam int RS1_MSB = 10;
    localparam int RS1_LSB = 9;
    localparam int RS2_MSB = 8;
    localparam int RS2_LSB = 7;
    localparam int IMM_MSB = 6;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_SLT  = 3'b110,
        OP_ADDI = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_e;

    typedef struct packed {
        opcode_e              op;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [IMM_W-1:0]     imm;
    } instr_t;

    function automatic instr_t decode(input logic [INSTR_W-1:0] raw);
        instr_t d;
        d.op  = opcode_e'(raw[OP_MSB:OP_LSB]);
        d.rd  = raw[RD_MSB:RD_LSB];
        d.rs1 = raw[RS1_MSB:RS1_LSB];
        d.rs2 = raw[RS2_MSB:RS2_LSB];
        d.imm = raw[IMM_MSB:IMM_LSB];
        return d;
    endfunction

endpackage

// File: rtl/reg_alu_core.sv
// Combinational ALU for the sequencer; all arithmetic wraps modulo 2^DATA_W.
module reg_alu_core
    import reg_alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  opcode_e                   op,
    input  logic signed [DATA_W-1:0]  a,
    input  logic signed [DATA_W-1:0]  b,
    input  logic signed [IMM_W-1:0]   imm,
    output logic signed [DATA_W-1:0]  result
);

    logic signed [DATA_W-1:0] immExt;

    assign immExt = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = (a < b) ? DATA_W'(1) : '0;
            OP_ADDI: result = a + immExt;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/reg_alu_seq.sv
// Four-cycle decode/read/execute/writeback sequencer in front of a 4x32 regfile.
// Optional status flags (zero_flag, neg_flag) enabled by REG_ALU_SEQ_STATUS_EN.
module reg_alu_seq
    import reg_alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    output logic [ADDR_W-1:0]  ReadReg1,
    output logic [ADDR_W-1:0]  ReadReg2,
    input  logic [DATA_W-1:0]  ReadData1,
    input  logic [DATA_W-1:0]  ReadData2,
    output logic [ADDR_W-1:0]  WriteReg,
    output logic [DATA_W-1:0]  WriteData,
    output logic               RegWrite,
`ifdef REG_ALU_SEQ_STATUS_EN
    output logic               zero_flag,
    output logic               neg_flag,
`endif
    output logic               done
);

    if (ADDR_W != REG_IDX_W) begin : gBadAddrW
        $error("reg_alu_seq: ADDR_W must be 2 for the 16-bit instruction encoding");
    end

    state_e  state, stateNext;
    instr_t  dec;
    logic    accept;

    opcode_e                  op_p0;
    logic [REG_IDX_W-1:0]     rd_p0;
    logic signed [IMM_W-1:0]  imm_p0;
    logic signed [DATA_W-1:0] opA_p1, opB_p1;
    logic signed [DATA_W-1:0] aluResult;

    assign dec    = decode(instr);
    assign accept = instr_valid && instr_ready;

    always_comb begin
        stateNext   = state;
        instr_ready = 1'b0;
        RegWrite    = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = reset;
                if (instr_valid) stateNext = READ;
            end
            READ: stateNext = EXEC;
            EXEC: stateNext = WB;
            WB: begin
                // Gated by reset so a WB-cycle reset aborts the write as well.
                RegWrite  = reset && (op_p0 != OP_NOP);
                done      = reset;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            ReadReg1  <= '0;
            ReadReg2  <= '0;
            WriteReg  <= '0;
            WriteData <= '0;
`ifdef REG_ALU_SEQ_STATUS_EN
            zero_flag <= 1'b0;
            neg_flag  <= 1'b0;
`endif
        end else begin
            state <= stateNext;
            if (accept) begin
                ReadReg1 <= ADDR_W'(dec.rs1);
                ReadReg2 <= ADDR_W'(dec.rs2);
            end
            // EXEC -> WB boundary: result and destination become the write port.
            if (state == EXEC) begin
                WriteData <= aluResult;
                WriteReg  <= ADDR_W'(rd_p0);
`ifdef REG_ALU_SEQ_STATUS_EN
                if (op_p0 != OP_NOP) begin
                    zero_flag <= (aluResult == '0);
                    neg_flag  <= aluResult[DATA_W-1];
                end
`endif
            end
        end
    end

    // IDLE -> READ latches the instruction; READ -> EXEC captures operands.
    always_ff @(posedge clk) begin
        if (state == IDLE && instr_valid) begin
            op_p0  <= dec.op;
            rd_p0  <= dec.rd;
            imm_p0 <= dec.imm;
        end
        if (state == READ) begin
            opA_p1 <= ReadData1;
            opB_p1 <= ReadData2;
        end
    end

    reg_alu_core #(
        .DATA_W (DATA_W)
    ) uCore (
        .op     (op_p0),
        .a      (opA_p1),
        .b      (opB_p1),
        .imm    (imm_p0),
        .result (aluResult)
    );

endmodule

// File: tb/tb_reg_alu_seq.sv
// Bench for reg_alu_seq wired to a 4x32 regfile; flag checks under REG_ALU_SEQ_STATUS_EN.
module tb_reg_alu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        instrValid;
    logic [15:0] instr;
    logic        instrReady;
    logic [1:0]  ReadReg1, ReadReg2, WriteReg;
    logic [31:0] ReadData1, ReadData2, WriteData;
    logic        RegWrite, done;
`ifdef REG_ALU_SEQ_STATUS_EN
    logic        zeroFlag, negFlag;
`endif

    logic [31:0] rf [4] = '{default: 32'h0};
    int cyc = 0;
    int nChecks = 0;
    int nPass = 0;

    typedef struct {
        logic [15:0] ins;
        logic [1:0]  rd;
        logic [31:0] data;
        bit          wr;
    } vec_t;

    typedef struct {
        bit          wr;
        logic [1:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        monE;
    vec_t        vecs[13];
    logic [31:0] expRf[4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ReadData1 = rf[ReadReg1];
    assign ReadData2 = rf[ReadReg2];
    always @(posedge clk) if (RegWrite) rf[WriteReg] <= WriteData;

    reg_alu_seq #(.DATA_W(32), .ADDR_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instrValid),
        .instr       (instr),
        .instr_ready (instrReady),
        .ReadReg1    (ReadReg1),
        .ReadReg2    (ReadReg2),
        .ReadData1   (ReadData1),
        .ReadData2   (ReadData2),
        .WriteReg    (WriteReg),
        .WriteData   (WriteData),
        .RegWrite    (RegWrite),
`ifdef REG_ALU_SEQ_STATUS_EN
        .zero_flag   (zeroFlag),
        .neg_flag    (negFlag),
`endif
        .done        (done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    endtask

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2,
                                        input logic [6:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    // Scoreboard: each done pulse retires the oldest expected writeback.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {31'b0, done}, 32'd0);
            end else begin
                monE = sb.pop_front();
                chk("regwrite", {31'b0, RegWrite}, {31'b0, monE.wr});
                if (monE.wr) begin
                    chk("writereg", {30'b0, WriteReg}, {30'b0, monE.rd});
                    chk("writedata", WriteData, monE.data);
                end
                chk("latency", cyc, monE.cyc);
            end
        end else if (RegWrite !== 1'b0) begin
            chk("regwrite_without_done", {31'b0, RegWrite}, 32'd0);
        end
    end

    task automatic issue(input logic [15:0] ins, input bit wr, input logic [1:0] rd,
                         input logic [31:0] data);
        bit ok = 1'b0;
        @(negedge clk);
        instrValid = 1'b1;
        instr      = ins;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (instrReady) begin
                sb.push_back('{wr, rd, data, cyc + 3});
                ok = 1'b1;
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
        end
        #1;
        instrValid = 1'b0;
        instr      = 16'($urandom);
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitDone();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic runOne(input string nm, input logic [15:0] ins, input bit wr,
                          input logic [1:0] rd, input logic [31:0] data);
        issue(ins, wr, rd, data);
        waitDone();
        if (wr) expRf[rd] = data;
        chk({"rf_", nm}, rf[rd], expRf[rd]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] seq[3];
        logic [31:0] seqData[3];
        int          acc[3];
        int          k;
        bit          sawWrite;

        for (int i = 0; i < 4; i++) expRf[i] = 32'h0;

        vecs[0]  = '{enc(3'b111, 2'd1, 2'd0, 2'd0, 7'd5),    2'd1, 32'h00000005, 1'b1};
        vecs[1]  = '{enc(3'b111, 2'd2, 2'd0, 2'd0, 7'h7F),   2'd2, 32'hFFFFFFFF, 1'b1};
        vecs[2]  = '{enc(3'b001, 2'd3, 2'd1, 2'd2, 7'd0),    2'd3, 32'h00000004, 1'b1};
        vecs[3]  = '{enc(3'b010, 2'd3, 2'd0, 2'd1, 7'd0),    2'd3, 32'hFFFFFFFB, 1'b1};
        vecs[4]  = '{enc(3'b110, 2'd3, 2'd2, 2'd1, 7'd0),    2'd3, 32'h00000001, 1'b1};
        vecs[5]  = '{enc(3'b101, 2'd3, 2'd1, 2'd2, 7'd0),    2'd3, 32'hFFFFFFFA, 1'b1};
        vecs[6]  = '{enc(3'b011, 2'd3, 2'd1, 2'd2, 7'd0),    2'd3, 32'h00000005, 1'b1};
        vecs[7]  = '{enc(3'b100, 2'd3, 2'd1, 2'd2, 7'd0),    2'd3, 32'hFFFFFFFF, 1'b1};
        vecs[8]  = '{enc(3'b110, 2'd3, 2'd1, 2'd2, 7'd0),    2'd3, 32'h00000000, 1'b1};
        vecs[9]  = '{enc(3'b111, 2'd3, 2'd1, 2'd3, 7'h40),   2'd3, 32'hFFFFFFC5, 1'b1};
        vecs[10] = '{enc(3'b000, 2'd1, 2'd2, 2'd3, 7'h15),   2'd1, 32'h00000000, 1'b0};
        vecs[11] = '{enc(3'b001, 2'd3, 2'd3, 2'd3, 7'd0),    2'd3, 32'hFFFFFF8A, 1'b1};
        vecs[12] = '{enc(3'b111, 2'd2, 2'd2, 2'd0, 7'd63),   2'd2, 32'h0000003E, 1'b1};

        reset      = 1'b0;
        instrValid = 1'b1;
        instr      = enc(3'b001, 2'd1, 2'd1, 2'd1, 7'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",     {31'b0, instrReady}, 32'd0);
        chk("rst_regwrite",  {31'b0, RegWrite},   32'd0);
        chk("rst_done",      {31'b0, done},       32'd0);
        chk("rst_writedata", WriteData,           32'd0);
        chk("rst_writereg",  {30'b0, WriteReg},   32'd0);
        chk("rst_readreg1",  {30'b0, ReadReg1},   32'd0);
        chk("rst_readreg2",  {30'b0, ReadReg2},   32'd0);
`ifdef REG_ALU_SEQ_STATUS_EN
        chk("rst_zero_flag", {31'b0, zeroFlag},   32'd0);
        chk("rst_neg_flag",  {31'b0, negFlag},    32'd0);
`endif
        instrValid = 1'b0;
        reset      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_ready", {31'b0, instrReady}, 32'd1);

        for (int i = 0; i < 13; i++)
            runOne($sformatf("v%0d", i), vecs[i].ins, vecs[i].wr, vecs[i].rd, vecs[i].data);

        // Back-to-back: valid held high across three instructions.
        seq[0] = enc(3'b111, 2'd3, 2'd1, 2'd0, 7'd1);  seqData[0] = 32'h00000006;
        seq[1] = enc(3'b111, 2'd3, 2'd3, 2'd0, 7'd1);  seqData[1] = 32'h00000007;
        seq[2] = enc(3'b001, 2'd3, 2'd3, 2'd1, 7'd0);  seqData[2] = 32'h0000000C;
        k = 0;
        @(negedge clk);
        instrValid = 1'b1;
        instr      = seq[0];
        for (int i = 0; i < 40 && k < 3; i++) begin
            if (instrReady) begin
                acc[k] = cyc;
                sb.push_back('{1'b1, 2'd3, seqData[k], cyc + 3});
                k++;
                @(posedge clk);
                @(negedge clk);
                if (k < 3) instr = seq[k];
                else instrValid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        instrValid = 1'b0;
        chk("b2b_count", k, 32'd3);
        if (k == 3) begin
            chk("b2b_gap01", acc[1] - acc[0], 32'd4);
            chk("b2b_gap12", acc[2] - acc[1], 32'd4);
        end
        waitDone();
        expRf[3] = 32'h0000000C;
        chk("rf_b2b", rf[3], expRf[3]);

        // Reset during EXEC of ADD r1,r1,r2 aborts the writeback.
        @(negedge clk);
        instrValid = 1'b1;
        instr      = enc(3'b001, 2'd1, 2'd1, 2'd2, 7'd0);
        chk("abort_ready", {31'b0, instrReady}, 32'd1);
        @(posedge clk);
        #1;
        instrValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        sawWrite = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sawWrite = sawWrite | RegWrite | done;
            if (i == 2) reset = 1'b1;
            @(negedge clk);
        end
        chk("abort_regwrite", {31'b0, sawWrite}, 32'd0);
        chk("abort_ready_after", {31'b0, instrReady}, 32'd1);
        chk("abort_rf1", rf[1], 32'h00000005);

        runOne("sub_zero", enc(3'b010, 2'd3, 2'd1, 2'd1, 7'd0), 1'b1, 2'd3, 32'h00000000);
`ifdef REG_ALU_SEQ_STATUS_EN
        chk("zero_flag_a", {31'b0, zeroFlag}, 32'd1);
        chk("neg_flag_a",  {31'b0, negFlag},  32'd0);
`endif
        runOne("sub_neg", enc(3'b010, 2'd3, 2'd0, 2'd1, 7'd0), 1'b1, 2'd3, 32'hFFFFFFFB);
`ifdef REG_ALU_SEQ_STATUS_EN
        chk("zero_flag_b", {31'b0, zeroFlag}, 32'd0);
        chk("neg_flag_b",  {31'b0, negFlag},  32'd1);
`endif
        runOne("nop_hold", enc(3'b000, 2'd0, 2'd0, 2'd0, 7'd0), 1'b0, 2'd0, 32'h0);
`ifdef REG_ALU_SEQ_STATUS_EN
        chk("zero_flag_nop", {31'b0, zeroFlag}, 32'd0);
        chk("neg_flag_nop",  {31'b0, negFlag},  32'd1);
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
